icache_direct_refill: RTL and testbench
=======================================

Name: icache_direct_refill

Overview:
- Parametrised direct-mapped instruction cache with multi-word blocks and a block-refill state machine.
- Sits between the fetch stage (PC) and main memory.
- Returns the instruction on a hit in the same cycle and stalls fetch (HitWrite low) on a miss.
- On a miss, it fetches the whole block word-by-word over a req/valid handshake. It also provides a flush and saturating hit/miss counters.

Parameters:
- ADDR_W, 32, address/PC width.
- DATA_W, 32, instruction word width.
- INDEX_W, 3, set index bits (2**INDEX_W lines).
- OFFSET_W, 2, word-offset bits (2**OFFSET_W words per block).
- CNT_W, 20, hit/miss counter width.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-low reset.
- PC  in  ADDR_W  fetch address; bits [1:0] ignored.
- Req  in  1  fetch request valid this cycle.
- Flush  in  1  invalidate all lines.
- HitWrite  out  1  hit; enables PCWrite/IFIDWrite (combinational).
- Data_Cache  out  DATA_W  instruction word (combinational, valid when HitWrite=1).
- MM_Req  out  1  main-memory read request (registered).
- MM_Addr  out  ADDR_W  word address of requested word (registered).
- MM_Valid  in  1  memory returns Data_MM this cycle.
- Data_MM  in  DATA_W  memory read data.
- Busy  out  1  refill in progress.
- CNT_HIT  out  CNT_W  hit counter.
- CNT_MISS  out  CNT_W  miss counter.

Behaviour:
- Address split:
  - tag = PC[ADDR_W-1 : 2+OFFSET_W+INDEX_W]
  - index = next INDEX_W bits
  - word = PC[2+OFFSET_W-1 : 2]
- Storage: per line a valid bit, tag, and 2**OFFSET_W data words.
- Reset (RESET=0 at edge):
  - state=IDLE, all valid=0, counters=0, MM_Req=0, MM_Addr=0, Busy=0, flush_pend=0.
  - HitWrite=0 and Data_Cache=0 follow combinationally.
  - Reset mid-refill aborts immediately; no partial line becomes valid.
- FSM states: IDLE, REFILL.
- IDLE:
  - hit = Req & valid[index] & tag match.
  - HitWrite=hit; Data_Cache=line word on hit, else 0.
  - On hit: CNT_HIT += 1, saturating at all-ones.
  - On Req & !hit: CNT_MISS += 1 (saturating).
    - Latch tag/index into miss registers; word counter wc=0.
    - MM_Req=1; MM_Addr={tag,index,wc,2'b00}.
    - Clear valid[index]; go to REFILL.
- REFILL:
  - HitWrite=0, Busy=1; PC and Req are ignored (miss address is latched).
  - On MM_Valid: write Data_MM to word wc of the line. If wc != last: wc+=1 and MM_Addr advances to the next word, with MM_Req held at 1. If wc == last: write tag, set valid=1, MM_Req=0, go to IDLE.
  - Refill order is word 0 to last, regardless of the missing word.
  - MM_Valid while MM_Req=0 is ignored.
- Refill latency:
  - Miss is detected in cycle 0; MM_Req rises at the end of cycle 0.
  - With MM_Valid held high, the line is valid after 2**OFFSET_W cycles.
  - The re-presented PC hits in the next IDLE cycle.
  - A hit/miss is counted once per Req cycle in IDLE only. Stalled re-requests after a refill count as hits.
- Flush:
  - In IDLE: all valid cleared at the edge. A Req in the same cycle is evaluated against pre-flush state and its outcome stands; its refill, if any, proceeds.
  - During REFILL: flush_pend is set, and all valid bits (including the refilled line) are cleared on the cycle after returning to IDLE.
- Counters never wrap. Simultaneous hit+flush counts the hit.

Decomposition:
- Shared package icache_pkg:
  - state enum (IDLE, REFILL).
  - localparams TAG_W = ADDR_W-2-OFFSET_W-INDEX_W, WORDS = 2**OFFSET_W, LINES = 2**INDEX_W.
  - A saturating-increment function.
- One natural sub-module, sat_counter (CNT_W parameter, inc, RESET), instantiated twice for CNT_HIT/CNT_MISS.
- Tag/data arrays stay inline.

Test Plan:
- Reset then Req PC=0x0000_0040, MM_Valid always 1, Data_MM=0xA0+word:
  - CNT_MISS=1.
  - MM_Addr sequence 0x40, 0x44, 0x48, 0x4C.
  - 4 cycles later HitWrite=1, Data_Cache=0xA0, CNT_HIT=1.
- After the line fill, PC=0x4C → hit, Data_Cache=0xA3. PC=0x440 (same index, different tag) → miss, CNT_MISS=2, refill from 0x440.
- MM_Valid asserted only every 3rd cycle during refill:
  - MM_Addr holds each word until MM_Valid.
  - Busy=1 throughout; no HitWrite until all 4 words are written.
- Flush pulse in IDLE after filling line 2 → next Req PC=0x40 misses. Flush during REFILL → line is still invalid afterwards (next access misses).
- RESET=0 mid-refill (after 2 words) → MM_Req=0, Busy=0, counters=0. The same PC then misses with full refill from word 0.
- CNT_W=4: 16 consecutive hits → CNT_HIT stays 15 (saturation).

Source files
------------

// File: rtl/icache_pkg.sv
// icache_pkg: shared types, default geometry and saturating increment for the instruction cache
package icache_pkg;

    typedef enum logic {IDLE, REFILL} state_e;

    localparam int ADDR_W_D   = 32;
    localparam int DATA_W_D   = 32;
    localparam int INDEX_W_D  = 3;
    localparam int OFFSET_W_D = 2;
    localparam int CNT_W_D    = 20;

    localparam int TAG_W = ADDR_W_D - 2 - OFFSET_W_D - INDEX_W_D;
    localparam int WORDS = 2 ** OFFSET_W_D;
    localparam int LINES = 2 ** INDEX_W_D;

    // Increment v unless it already holds the all-ones value of a w-bit counter
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
        logic [63:0] m;
        m = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (v >= m) ? v : v + 64'd1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping
module sat_counter import icache_pkg::*; #(
    parameter int CNT_W = CNT_W_D
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: bump on an event, holding at the ceiling
    always_comb cnt_d = inc_i ? CNT_W'(sat_inc(64'(cnt_q), CNT_W)) : cnt_q;

    // Count register with synchronous active-low clear
    always_ff @(posedge clk_i) cnt_q <= !rst_ni ? '0 : cnt_d;

    assign cnt_o = cnt_q;

endmodule

// File: rtl/icache_direct_refill.sv
// icache_direct_refill: direct-mapped I-cache with word-by-word block refill, flush and hit/miss counters
module icache_direct_refill import icache_pkg::*; #(
    parameter int ADDR_W   = ADDR_W_D,
    parameter int DATA_W   = DATA_W_D,
    parameter int INDEX_W  = INDEX_W_D,
    parameter int OFFSET_W = OFFSET_W_D,
    parameter int CNT_W    = CNT_W_D
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] PC,
    input  logic              Req,
    input  logic              Flush,
    output logic              HitWrite,
    output logic [DATA_W-1:0] Data_Cache,
    output logic              MM_Req,
    output logic [ADDR_W-1:0] MM_Addr,
    input  logic              MM_Valid,
    input  logic [DATA_W-1:0] Data_MM,
    output logic              Busy,
    output logic [CNT_W-1:0]  CNT_HIT,
    output logic [CNT_W-1:0]  CNT_MISS
);

    localparam int TB = ADDR_W - 2 - OFFSET_W - INDEX_W;
    localparam int NW = 2 ** OFFSET_W;
    localparam int NL = 2 ** INDEX_W;

    state_e               state_q;
    logic [NL-1:0]        valid_q;
    logic [TB-1:0]        tag_q  [NL];
    logic [DATA_W-1:0]    data_q [NL*NW];
    logic [TB-1:0]        miss_tag_q;
    logic [INDEX_W-1:0]   miss_idx_q;
    logic [OFFSET_W-1:0]  wc_q;
    logic                 flush_pend_q, mm_req_q, busy_q;
    logic [ADDR_W-1:0]    mm_addr_q;

    logic [TB-1:0]        pc_tag;
    logic [INDEX_W-1:0]   pc_idx;
    logic [OFFSET_W-1:0]  pc_word;
    logic                 hit, miss, fill, last;
    logic                 unused_pc;

    assign pc_tag    = PC[ADDR_W-1 -: TB];
    assign pc_idx    = PC[2+OFFSET_W +: INDEX_W];
    assign pc_word   = PC[2 +: OFFSET_W];
    assign unused_pc = ^PC[1:0];

    assign hit  = (state_q == IDLE) && Req && valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
    assign miss = (state_q == IDLE) && Req && !hit;
    assign fill = (state_q == REFILL) && MM_Valid && mm_req_q;
    assign last = (wc_q == '1);

    assign HitWrite   = hit;
    assign Data_Cache = hit ? data_q[{pc_idx, pc_word}] : '0;
    assign MM_Req     = mm_req_q;
    assign MM_Addr    = mm_addr_q;
    assign Busy       = busy_q;

    // Control FSM: miss capture, refill sequencing, flush and valid bits
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            flush_pend_q <= 1'b0;
            mm_req_q     <= 1'b0;
            mm_addr_q    <= '0;
            busy_q       <= 1'b0;
            wc_q         <= '0;
            miss_tag_q   <= '0;
            miss_idx_q   <= '0;
        end else if (state_q == IDLE) begin
            if (Flush || flush_pend_q) valid_q <= '0;
            flush_pend_q <= 1'b0;
            if (miss) begin
                miss_tag_q      <= pc_tag;
                miss_idx_q      <= pc_idx;
                wc_q            <= '0;
                mm_req_q        <= 1'b1;
                busy_q          <= 1'b1;
                mm_addr_q       <= {pc_tag, pc_idx, {OFFSET_W{1'b0}}, 2'b00};
                valid_q[pc_idx] <= 1'b0;
                state_q         <= REFILL;
            end
        end else begin
            if (Flush) flush_pend_q <= 1'b1;
            if (fill) begin
                if (last) begin
                    valid_q[miss_idx_q] <= 1'b1;
                    mm_req_q            <= 1'b0;
                    busy_q              <= 1'b0;
                    state_q             <= IDLE;
                end else begin
                    wc_q      <= wc_q + 1'b1;
                    mm_addr_q <= {miss_tag_q, miss_idx_q, wc_q + 1'b1, 2'b00};
                end
            end
        end
    end

    // Line storage: one word per accepted beat, tag written with the final word
    always_ff @(posedge CLK) begin
        if (RESET && fill) begin
            data_q[{miss_idx_q, wc_q}] <= Data_MM;
            if (last) tag_q[miss_idx_q] <= miss_tag_q;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_cnt_hit (
        .clk_i (CLK),
        .rst_ni(RESET),
        .inc_i (hit),
        .cnt_o (CNT_HIT)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_miss (
        .clk_i (CLK),
        .rst_ni(RESET),
        .inc_i (miss),
        .cnt_o (CNT_MISS)
    );

endmodule

// File: tb/tb_icache_direct_refill.sv
// tb_icache_direct_refill: directed plus random stimulus against a behavioural cache model
module tb_icache_direct_refill;

    logic        CLK = 1'b0, RESET = 1'b0, Req = 1'b0, Flush = 1'b0, MM_Valid = 1'b0;
    logic [31:0] PC = '0, Data_MM = '0;
    logic        hw, mreq, busy, hw4, mreq4, busy4;
    logic [31:0] dc, maddr, dc4, maddr4;
    logic [19:0] ch, cm;
    logic [3:0]  ch4, cm4;

    int total = 0, bad = 0;
    bit rnd = 0;

    always #5 CLK = ~CLK;

    icache_direct_refill dut (
        .CLK(CLK), .RESET(RESET), .PC(PC), .Req(Req), .Flush(Flush),
        .HitWrite(hw), .Data_Cache(dc), .MM_Req(mreq), .MM_Addr(maddr),
        .MM_Valid(MM_Valid), .Data_MM(Data_MM), .Busy(busy),
        .CNT_HIT(ch), .CNT_MISS(cm)
    );

    icache_direct_refill #(.CNT_W(4)) dut4 (
        .CLK(CLK), .RESET(RESET), .PC(PC), .Req(Req), .Flush(Flush),
        .HitWrite(hw4), .Data_Cache(dc4), .MM_Req(mreq4), .MM_Addr(maddr4),
        .MM_Valid(MM_Valid), .Data_MM(Data_MM), .Busy(busy4),
        .CNT_HIT(ch4), .CNT_MISS(cm4)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Behavioural model: lines as arrays, refill as a base address plus a count of words received
    bit          m_val [8];
    logic [24:0] m_tag [8];
    logic [31:0] m_data [8][4];
    bit          m_busy = 0, m_fp = 0, armed = 0;
    logic [31:0] m_base = '0, m_addr = '0;
    int          m_got = 0, n_hit = 0, n_miss = 0;

    initial begin
        logic [2:0]  idx;
        logic [1:0]  wd;
        logic [24:0] tg;
        bit          e_hit;
        logic [31:0] e_data;
        forever begin
            @(negedge CLK);
            idx    = PC[6:4];
            wd     = PC[3:2];
            tg     = PC[31:7];
            e_hit  = armed && !m_busy && Req && m_val[idx] && (m_tag[idx] == tg);
            e_data = e_hit ? m_data[idx][wd] : 32'd0;
            if (armed) begin
                check("hit", 64'(hw), 64'(e_hit));
                check("data", 64'(dc), 64'(e_data));
                check("mm_req", 64'(mreq), 64'(m_busy));
                check("mm_addr", 64'(maddr), 64'(m_addr));
                check("busy", 64'(busy), 64'(m_busy));
                check("cnt_hit", 64'(ch), 64'(sat(n_hit, 20'hFFFFF)));
                check("cnt_miss", 64'(cm), 64'(sat(n_miss, 20'hFFFFF)));
                check("hit4", 64'(hw4), 64'(e_hit));
                check("cnt4_hit", 64'(ch4), 64'(sat(n_hit, 15)));
                check("cnt4_miss", 64'(cm4), 64'(sat(n_miss, 15)));
            end
            if (!RESET) begin
                m_val  = '{default: 0};
                m_busy = 0;
                m_fp   = 0;
                m_addr = '0;
                n_hit  = 0;
                n_miss = 0;
                armed  = 1;
            end else if (!m_busy) begin
                if (Flush || m_fp) m_val = '{default: 0};
                m_fp = 0;
                if (Req && e_hit) n_hit++;
                else if (Req) begin
                    n_miss++;
                    m_busy   = 1;
                    m_base   = {PC[31:4], 4'h0};
                    m_got    = 0;
                    m_addr   = m_base;
                    m_val[idx] = 0;
                end
            end else begin
                if (Flush) m_fp = 1;
                if (MM_Valid) begin
                    m_data[m_base[6:4]][m_got] = Data_MM;
                    m_got++;
                    if (m_got == 4) begin
                        m_tag[m_base[6:4]] = m_base[31:7];
                        m_val[m_base[6:4]] = 1;
                        m_busy = 0;
                    end else m_addr = m_base + 32'(4 * m_got);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
        Data_MM = rnd ? $urandom : 32'hA0 + {30'd0, maddr[3:2]};
    endtask

    task automatic wait_idle();
        int n;
        for (n = 0; busy && n < 50; n++) cyc();
        check("idle_timeout", 64'(busy), 64'd0);
    endtask

    initial begin
        cyc();
        cyc();
        #1;
        check("rst_hit", 64'(hw), 64'd0);
        check("rst_mreq", 64'(mreq), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_cnth", 64'(ch), 64'd0);
        check("rst_cntm", 64'(cm), 64'd0);
        check("rst_data", 64'(dc), 64'd0);
        RESET = 1; PC = 32'h40; Req = 1; MM_Valid = 1;
        #1 check("cold_miss", 64'(hw), 64'd0);
        cyc();
        check("miss_cnt1", 64'(cm), 64'd1);
        for (int k = 0; k < 4; k++) begin
            check("addr_seq", 64'(maddr), 64'(32'h40 + 4 * k));
            check("req_held", 64'(mreq), 64'd1);
            cyc();
        end
        #1;
        check("fill_hit", 64'(hw), 64'd1);
        check("fill_data", 64'(dc), 64'hA0);
        cyc();
        check("hit_cnt1", 64'(ch), 64'd1);
        PC = 32'h4C;
        #1;
        check("word3_hit", 64'(hw), 64'd1);
        check("word3_data", 64'(dc), 64'hA3);
        cyc();
        PC = 32'h440; MM_Valid = 0;
        #1 check("conflict_miss", 64'(hw), 64'd0);
        cyc();
        check("miss_cnt2", 64'(cm), 64'd2);
        check("conflict_addr", 64'(maddr), 64'h440);
        for (int i = 0; i < 12; i++) begin
            MM_Valid = (i % 3 == 2);
            #1;
            check("slow_stall", 64'(hw), 64'd0);
            check("slow_busy", 64'(busy), 64'd1);
            check("slow_addr", 64'(maddr), 64'(32'h440 + 4 * (i / 3)));
            cyc();
        end
        MM_Valid = 0;
        #1;
        check("slow_hit", 64'(hw), 64'd1);
        check("slow_data", 64'(dc), 64'hA0);
        cyc();
        Req = 0; Flush = 1;
        cyc();
        Flush = 0; PC = 32'h40; Req = 1; MM_Valid = 1;
        #1 check("flush_idle_miss", 64'(hw), 64'd0);
        cyc();
        Req = 0; Flush = 1;
        cyc();
        Flush = 0;
        wait_idle();
        cyc();
        Req = 1;
        #1 check("flush_refill_miss", 64'(hw), 64'd0);
        cyc();
        cyc();
        cyc();
        RESET = 0;
        cyc();
        check("abort_mreq", 64'(mreq), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_cnth", 64'(ch), 64'd0);
        check("abort_cntm", 64'(cm), 64'd0);
        RESET = 1;
        #1 check("abort_miss", 64'(hw), 64'd0);
        cyc();
        check("abort_word0", 64'(maddr), 64'h40);
        wait_idle();
        for (int i = 0; i < 16; i++) cyc();
        check("hit16", 64'(ch), 64'd16);
        check("sat4", 64'(ch4), 64'd15);
        rnd = 1;
        for (int i = 0; i < 3000; i++) begin
            RESET    = ($urandom_range(0, 199) != 0);
            Req      = ($urandom_range(0, 9) < 7);
            Flush    = ($urandom_range(0, 29) == 0);
            MM_Valid = ($urandom_range(0, 9) < 6);
            PC       = (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
            cyc();
        end
        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
